alu_sweep_sequencer: RTL and testbench
======================================

// Module: alu_sweep_sequencer
// PURPOSE
// Upstream driver for the 5-bit mini-ALU multiplexer. On a start pulse it latches two operands,
// steps the mux select code through 0..NUM_OPS-1 (each held HOLD_CYCLES cycles), samples the
// mux result at the end of each hold window, and emits one {sel,result} record per code over a
// valid/ready stream. The stream is consumed by the result logger/display stage.
// PARAMETERS
// WIDTH        5   operand/result width (matches mux ina/inb/out)
// SEL_W        3   select width
// NUM_OPS      8   number of select codes swept, 1..2**SEL_W
// HOLD_CYCLES  4   cycles each select code is held before sampling, >=1
// PORTS
// clk        in   1        rising-edge clock
// rst        in   1        synchronous, active-high reset
// start      in   1        begin sweep; sampled only in IDLE
// op_a       in   WIDTH    operand A, latched on accepted start
// op_b       in   WIDTH    operand B, latched on accepted start
// mux_ina    out  WIDTH    to mux ina (latched op_a)
// mux_inb    out  WIDTH    to mux inb (latched op_b)
// mux_sel    out  SEL_W    to mux sel
// mux_out    in   WIDTH    from mux out (combinational function of ina/inb/sel)
// res_valid  out  1        result record valid
// res_ready  in   1        downstream accepts record
// res_sel    out  SEL_W    select code of record
// res_data   out  WIDTH    sampled mux_out for that code
// busy       out  1        high from accepted start until done pulse (inclusive)
// done       out  1        one-cycle pulse after last record is accepted
// BEHAVIOUR
// - Reset: state=IDLE; mux_ina/mux_inb/mux_sel/res_sel/res_data=0; res_valid/busy/done=0.
// - rst is sampled every clk edge; asserting it mid-sweep aborts immediately, no done pulse,
//   any pending record is dropped.
// - States: IDLE -> HOLD -> EMIT -> (HOLD | FIN) -> IDLE.
// - IDLE: start=1 -> latch op_a/op_b onto mux_ina/mux_inb, mux_sel=0, hold_cnt=0, busy=1, go HOLD.
//   start=0 -> stay. start while busy is ignored (not queued).
// - HOLD: hold_cnt increments each cycle; on the cycle hold_cnt==HOLD_CYCLES-1, register
//   res_data<=mux_out, res_sel<=mux_sel, res_valid<=1, go EMIT. mux_sel stable throughout.
// - EMIT: res_valid, res_sel, res_data held stable until res_valid&&res_ready.
//   On transfer: res_valid<=0; if mux_sel==NUM_OPS-1 go FIN, else mux_sel<=mux_sel+1,
//   hold_cnt<=0, go HOLD. mux_sel never wraps within a sweep.
// - FIN: done=1 and busy=1 for one cycle, then IDLE with busy=0. mux_ina/inb/sel keep last values.
// - Latency: first record valid HOLD_CYCLES cycles after the start edge. Sweep with res_ready
//   tied high takes NUM_OPS*(HOLD_CYCLES+1)+1 cycles from start to done.
// - res_ready=0 stalls only the sequencer; mux inputs do not change during the stall.
// - res_ready asserted without res_valid has no effect.
// - Widths: operands pass through unmodified. No arithmetic on data. Counters are sized for
//   NUM_OPS and HOLD_CYCLES without overflow.
// TESTING
// Bench mux model: mux_out = (mux_ina + {2'b0,mux_sel}) mod 32.
// 1 Reset: assert rst 2 cycles -> all outputs 0, state IDLE; start held with rst=1 is ignored.
// 2 Nominal: op_a=5'b10110, op_b=5'b01011, start 1 cycle, res_ready=1 -> 8 records,
//   sel 0..7, data 22..29. First record valid 4 cycles after start. done at cycle 41. busy low after.
// 3 Backpressure: res_ready low 10 cycles on the sel=3 record -> record stable, mux_sel stays 3,
//   no loss or duplication, total records=8.
// 4 Busy start: pulse start with op_a=5'b00001 mid-sweep -> ignored, all data from op_a=22.
// 5 Reset mid-sweep: rst during sel=5 HOLD -> next cycle outputs 0, no done.
//   A fresh start then sweeps normally from sel=0.
// 6 Params: NUM_OPS=3, HOLD_CYCLES=1 -> 3 records sel 0..2, done 7 cycles after start.

Source files
------------

// File: rtl/alu_sweep_sequencer_if.sv
// Handshake/bus bundle between the sweep sequencer, the mini-ALU mux and the
// result consumer.
interface alu_sweep_sequencer_if #(
  parameter int WIDTH = 5,
  parameter int SEL_W = 3
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] mux_ina;
  logic [WIDTH-1:0] mux_inb;
  logic [SEL_W-1:0] mux_sel;
  logic [WIDTH-1:0] mux_out;
  logic             res_valid;
  logic             res_ready;
  logic [SEL_W-1:0] res_sel;
  logic [WIDTH-1:0] res_data;
  logic             busy;
  logic             done;

  modport master (
    input  start, op_a, op_b, mux_out, res_ready,
    output mux_ina, mux_inb, mux_sel, res_valid, res_sel, res_data, busy, done
  );

  modport slave (
    output start, op_a, op_b, mux_out, res_ready,
    input  mux_ina, mux_inb, mux_sel, res_valid, res_sel, res_data, busy, done
  );
endinterface

// File: rtl/alu_sweep_sequencer.sv
// Steps the mini-ALU mux select through NUM_OPS codes on latched operands and
// streams one {sel,result} record per code over a valid/ready handshake.
module alu_sweep_sequencer #(
  parameter int WIDTH       = 5,
  parameter int SEL_W       = 3,
  parameter int NUM_OPS     = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  alu_sweep_sequencer_if.master io_seq
);

  // state | meaning
  // IDLE  | waiting for start
  // HOLD  | mux_sel settling; sample mux_out on terminal count
  // EMIT  | record presented, waiting for res_ready
  // FIN   | one-cycle done pulse
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_EMIT = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_OPS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [WIDTH-1:0] r_mux_ina;
  logic [WIDTH-1:0] r_mux_inb;
  logic [SEL_W-1:0] r_mux_sel;
  logic [SEL_W-1:0] r_res_sel;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_valid;
  logic             w_hold_tc;
  logic             w_last_sel;
  logic             w_xfer;

  // Hold timer is a down-counter; sampling happens on its terminal count.
  assign w_hold_tc  = (r_hold_cnt == '0);
  assign w_last_sel = (r_mux_sel == SEL_LAST);
  assign w_xfer     = r_res_valid && io_seq.res_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (io_seq.start) w_state_nxt = S_HOLD;
      S_HOLD: if (w_hold_tc)    w_state_nxt = S_EMIT;
      S_EMIT: if (w_xfer)       w_state_nxt = w_last_sel ? S_FIN : S_HOLD;
      S_FIN:                    w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold_cnt  <= '0;
      r_mux_ina   <= '0;
      r_mux_inb   <= '0;
      r_mux_sel   <= '0;
      r_res_sel   <= '0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_seq.start) begin
            r_mux_ina  <= io_seq.op_a;
            r_mux_inb  <= io_seq.op_b;
            r_mux_sel  <= '0;
            r_hold_cnt <= HOLD_LOAD;
          end
        end
        S_HOLD: begin
          if (w_hold_tc) begin
            r_res_data  <= io_seq.mux_out;
            r_res_sel   <= r_mux_sel;
            r_res_valid <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
          end
        end
        S_EMIT: begin
          if (w_xfer) begin
            r_res_valid <= 1'b0;
            if (!w_last_sel) begin
              r_mux_sel  <= r_mux_sel + SEL_W'(1);
              r_hold_cnt <= HOLD_LOAD;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign io_seq.mux_ina   = r_mux_ina;
  assign io_seq.mux_inb   = r_mux_inb;
  assign io_seq.mux_sel   = r_mux_sel;
  assign io_seq.res_valid = r_res_valid;
  assign io_seq.res_sel   = r_res_sel;
  assign io_seq.res_data  = r_res_data;
  assign io_seq.busy      = (r_state != S_IDLE);
  assign io_seq.done      = (r_state == S_FIN);

endmodule

// File: tb/tb_alu_sweep_sequencer.sv
// Directed bench for alu_sweep_sequencer: table of full sweeps on the default
// configuration plus hand sequences for reset and a 3-code/1-cycle variant.
module tb_alu_sweep_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_sweep_sequencer_if #(.WIDTH(5), .SEL_W(3)) ifa ();
  alu_sweep_sequencer_if #(.WIDTH(5), .SEL_W(3)) ifb ();

  alu_sweep_sequencer #(.WIDTH(5), .SEL_W(3), .NUM_OPS(8), .HOLD_CYCLES(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .io_seq(ifa.master));
  alu_sweep_sequencer #(.WIDTH(5), .SEL_W(3), .NUM_OPS(3), .HOLD_CYCLES(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .io_seq(ifb.master));

  // Mux model: out = (ina + sel) mod 32
  assign ifa.mux_out = ifa.mux_ina + {2'b00, ifa.mux_sel};
  assign ifb.mux_out = ifb.mux_ina + {2'b00, ifb.mux_sel};

  typedef struct {
    logic [4:0] op_a;
    logic [4:0] op_b;
    int         stall_len;
    bit         poke_start;
    logic [4:0] exp_data [8];
    int         exp_done;
  } vec_t;

  vec_t vecs [5];
  int   n_tests = 0;
  int   n_fail  = 0;

  int rec_sel  [$];
  int rec_data [$];
  int done_cyc;
  int first_valid;
  bit stall_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle index 0 is the sample point just after the edge that accepts start.
  task automatic sweep_a(input vec_t v);
    int stall_cnt;
    int stall_data;
    stall_cnt   = 0;
    stall_data  = 0;
    stall_bad   = 1'b0;
    done_cyc    = -1;
    first_valid = -1;
    rec_sel.delete();
    rec_data.delete();
    ifa.op_a  = v.op_a;
    ifa.op_b  = v.op_b;
    ifa.start = 1'b1;
    ifa.res_ready = 1'b1;
    step();
    ifa.start = 1'b0;
    check("start_busy", ifa.busy, 1);
    check("start_ina", ifa.mux_ina, v.op_a);
    check("start_sel", ifa.mux_sel, 0);
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (ifa.done) begin
        done_cyc = cyc;
        break;
      end
      if (first_valid < 0 && ifa.res_valid) first_valid = cyc;
      if (v.poke_start) begin
        ifa.start = (cyc == 10);
        ifa.op_a  = (cyc == 10) ? 5'd1 : v.op_a;
      end
      ifa.res_ready = 1'b1;
      if (ifa.res_valid && ifa.res_sel == 3'd3 && stall_cnt < v.stall_len) begin
        if (stall_cnt == 0) stall_data = int'(ifa.res_data);
        else if (int'(ifa.res_data) != stall_data || ifa.mux_sel != 3'd3) stall_bad = 1'b1;
        ifa.res_ready = 1'b0;
        stall_cnt++;
      end
      if (ifa.res_valid && ifa.res_ready) begin
        rec_sel.push_back(int'(ifa.res_sel));
        rec_data.push_back(int'(ifa.res_data));
      end
      step();
    end
    ifa.start = 1'b0;
    ifa.res_ready = 1'b1;
  endtask

  initial begin
    // Default sweep; with ready high done appears NUM_OPS*(HOLD+1) edges after
    // the start edge, i.e. in the 41st cycle counting the start cycle.
    vecs[0] = '{5'd22, 5'd11, 0,  1'b0,
                '{5'd22, 5'd23, 5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29}, 40};
    vecs[1] = '{5'd22, 5'd11, 10, 1'b0,
                '{5'd22, 5'd23, 5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29}, 50};
    vecs[2] = '{5'd22, 5'd11, 0,  1'b1,
                '{5'd22, 5'd23, 5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29}, 40};
    vecs[3] = '{5'd30, 5'd7,  0,  1'b0,
                '{5'd30, 5'd31, 5'd0,  5'd1,  5'd2,  5'd3,  5'd4,  5'd5},  40};
    vecs[4] = '{5'd0,  5'd31, 3,  1'b0,
                '{5'd0,  5'd1,  5'd2,  5'd3,  5'd4,  5'd5,  5'd6,  5'd7},  43};

    ifa.start = 1'b0; ifa.op_a = 5'd0; ifa.op_b = 5'd0; ifa.res_ready = 1'b1;
    ifb.start = 1'b0; ifb.op_a = 5'd0; ifb.op_b = 5'd0; ifb.res_ready = 1'b1;

    // Reset with start held high: start must be ignored.
    rst = 1'b1;
    ifa.start = 1'b1; ifa.op_a = 5'd9; ifa.op_b = 5'd9;
    step();
    step();
    check("rst_ina",   ifa.mux_ina,   0);
    check("rst_inb",   ifa.mux_inb,   0);
    check("rst_sel",   ifa.mux_sel,   0);
    check("rst_rsel",  ifa.res_sel,   0);
    check("rst_rdata", ifa.res_data,  0);
    check("rst_valid", ifa.res_valid, 0);
    check("rst_busy",  ifa.busy,      0);
    check("rst_done",  ifa.done,      0);
    rst = 1'b0;
    ifa.start = 1'b0;
    step();
    check("rst_idle_busy", ifa.busy, 0);

    // Reset in the middle of the sel=5 hold window.
    ifa.op_a = 5'd22; ifa.op_b = 5'd11; ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (ifa.busy && ifa.mux_sel == 3'd5 && !ifa.res_valid) begin
          found = 1'b1;
          break;
        end
        step();
      end
      check("mid_reach_sel5", found, 1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_ina",   ifa.mux_ina,   0);
    check("mid_rst_sel",   ifa.mux_sel,   0);
    check("mid_rst_valid", ifa.res_valid, 0);
    check("mid_rst_busy",  ifa.busy,      0);
    begin
      bit saw_done;
      saw_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
        if (ifa.done || ifa.busy) saw_done = 1'b1;
        step();
      end
      check("mid_rst_no_done", saw_done, 0);
    end

    // Table-driven sweeps on the default configuration.
    for (int k = 0; k < 5; k++) begin
      sweep_a(vecs[k]);
      check($sformatf("v%0d_nrec", k), rec_sel.size(), 8);
      for (int i = 0; i < 8; i++) begin
        if (i < rec_sel.size()) begin
          check($sformatf("v%0d_sel%0d", k, i),  rec_sel[i],  i);
          check($sformatf("v%0d_data%0d", k, i), rec_data[i], vecs[k].exp_data[i]);
        end
      end
      check($sformatf("v%0d_first_valid", k), first_valid, 4);
      check($sformatf("v%0d_done_cyc", k), done_cyc, vecs[k].exp_done);
      check($sformatf("v%0d_fin_ina", k), ifa.mux_ina, vecs[k].op_a);
      check($sformatf("v%0d_fin_inb", k), ifa.mux_inb, vecs[k].op_b);
      check($sformatf("v%0d_fin_sel", k), ifa.mux_sel, 7);
      if (vecs[k].stall_len > 0) check($sformatf("v%0d_stall_stable", k), stall_bad, 0);
      step();
      check($sformatf("v%0d_post_done", k), ifa.done, 0);
      check($sformatf("v%0d_post_busy", k), ifa.busy, 0);
    end

    // Reduced configuration: 3 codes, 1-cycle hold, done 6 edges after start.
    begin
      int b_sel  [$];
      int b_data [$];
      int b_done;
      int b_first;
      b_done  = -1;
      b_first = -1;
      ifb.op_a = 5'd10; ifb.op_b = 5'd3; ifb.start = 1'b1;
      step();
      ifb.start = 1'b0;
      for (int cyc = 0; cyc < 50; cyc++) begin
        if (ifb.done) begin
          b_done = cyc;
          break;
        end
        if (b_first < 0 && ifb.res_valid) b_first = cyc;
        if (ifb.res_valid && ifb.res_ready) begin
          b_sel.push_back(int'(ifb.res_sel));
          b_data.push_back(int'(ifb.res_data));
        end
        step();
      end
      check("b_nrec", b_sel.size(), 3);
      if (b_sel.size() == 3) begin
        check("b_sel0", b_sel[0], 0);  check("b_data0", b_data[0], 10);
        check("b_sel1", b_sel[1], 1);  check("b_data1", b_data[1], 11);
        check("b_sel2", b_sel[2], 2);  check("b_data2", b_data[2], 12);
      end
      check("b_first_valid", b_first, 1);
      check("b_done_cyc", b_done, 6);
      step();
      check("b_post_busy", ifb.busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
